// File: rtl/rv_hazard_scoreboard_pkg.sv
// Shared types for the RV hazard/scheduler unit.
//   fwd_sel_e     : E-stage operand source select (regfile / W / M)
//   sched_state_e : data-memory wait/timeout FSM states
//   fwd_pick      : M-over-W forwarding priority helper
package rv_hazard_scoreboard_pkg;

   typedef enum logic [1:0] {
      FWD_RF = 2'b00,
      FWD_W  = 2'b01,
      FWD_M  = 2'b10
   } fwd_sel_e;

   typedef enum logic [1:0] {
      ST_RUN,
      ST_MEM_WAIT,
      ST_MEM_ERR
   } sched_state_e;

   // The M stage holds the younger result, so it shadows W.
   function automatic fwd_sel_e fwd_pick(input logic hit_m, input logic hit_w);
      if (hit_m) return FWD_M;
      if (hit_w) return FWD_W;
      return FWD_RF;
   endfunction

endpackage

// File: rtl/rv_hazard_scoreboard_md.sv
// Multi-cycle mul/div register scoreboard.
// Holds one pending-write bit per architectural register plus the count of
// outstanding mul/div ops, and reports the D-stage hazards that depend on them.
//   clk, rst_n              clock, asynchronous active-low reset
//   rs1D/rs2D/rdD, use_*    D-stage register lookups
//   reg_writeD, md_issueD   D-stage write enable / mul-div marker
//   issue, issue_rd         qualified mul/div issue leaving E
//   wb_valid, wb_rd         mul/div writeback
//   md_hazard               RAW | WAW | structural hazard for D
module rv_md_scoreboard
   import rv_hazard_scoreboard_pkg::*;
#(
   parameter int unsigned NREG     = 32,
   parameter int unsigned MD_DEPTH = 2,
   parameter int unsigned REG_AW   = $clog2(NREG)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [REG_AW-1:0] rs1D,
   input  logic [REG_AW-1:0] rs2D,
   input  logic [REG_AW-1:0] rdD,
   input  logic              use_rs1D,
   input  logic              use_rs2D,
   input  logic              reg_writeD,
   input  logic              md_issueD,
   input  logic              issue,
   input  logic [REG_AW-1:0] issue_rd,
   input  logic              wb_valid,
   input  logic [REG_AW-1:0] wb_rd,
   output logic              md_hazard
);

   localparam int unsigned CNT_AW = $clog2(MD_DEPTH + 1);

   logic [NREG-1:0]   sb_q, sb_d;
   logic [CNT_AW-1:0] cnt_q, cnt_d;
   logic              full, raw, waw;

   // Set is applied after clear so a same-register set/clear leaves the bit set.
   always_comb begin
      sb_d = sb_q;
      if (wb_valid) sb_d[wb_rd] = 1'b0;
      if (issue && (issue_rd != '0)) sb_d[issue_rd] = 1'b1;
      sb_d[0] = 1'b0;
   end

   // An issue to x0 still occupies the unit and still writes back, so the
   // count tracks every qualified issue even though no sb bit is set for it.
   always_comb begin
      cnt_d = cnt_q;
      if (issue && !wb_valid) begin
         if (cnt_q != CNT_AW'(MD_DEPTH)) cnt_d = cnt_q + CNT_AW'(1);
      end else if (!issue && wb_valid) begin
         if (cnt_q != '0) cnt_d = cnt_q - CNT_AW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sb_q  <= '0;
         cnt_q <= '0;
      end else begin
         sb_q  <= sb_d;
         cnt_q <= cnt_d;
      end
   end

   assign full      = (cnt_q == CNT_AW'(MD_DEPTH));
   assign raw       = (use_rs1D && sb_q[rs1D]) || (use_rs2D && sb_q[rs2D]);
   assign waw       = reg_writeD && sb_q[rdD];
   assign md_hazard = raw || waw || (md_issueD && full);

   // A writeback with nothing outstanding means the mul/div unit lost track.
   a_no_underflow : assert property (@(posedge clk) disable iff (!rst_n)
      !(wb_valid && !issue && (cnt_q == '0)));

endmodule

// File: rtl/rv_hazard_scoreboard.sv
// Pipeline hazard/scheduler unit for the 5-stage RV core (F/D/E/M/W).
// E-stage forwarding, D-stage load-use and mul/div scoreboard hazards,
// branch-redirect flushing, and a data-memory wait/timeout FSM.
//   clk, rst_n                     clock, asynchronous active-low reset
//   rs1D/rs2D/rdD, use_rs*D        D-stage registers and source-use flags
//   reg_writeD, md_issueD          D-stage controls
//   rs1E/rs2E/rdE, *E controls     E-stage registers and controls
//   rdM/rdW, reg_writeM/W          M/W destinations for forwarding
//   md_wb_valid, md_wb_rd          mul/div writeback
//   dmem_reqM, dmem_ready          M-stage memory handshake
//   br_taken                       E-stage redirect
//   forward_rs1E/rs2E              00 regfile, 10 from M, 01 from W
//   stallF/D/E/M, flushD/E/M/W     pipeline register controls
//   mem_err                        registered one-cycle timeout pulse
//   stall_cycles                   saturating count of cycles with stallF
module rv_hazard_scoreboard
   import rv_hazard_scoreboard_pkg::*;
#(
   parameter int unsigned NREG     = 32,
   parameter int unsigned MD_DEPTH = 2,
   parameter int unsigned MEM_TMO  = 16,
   parameter int unsigned CNT_W    = 16,
   localparam int unsigned REG_AW  = $clog2(NREG)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [REG_AW-1:0] rs1D,
   input  logic [REG_AW-1:0] rs2D,
   input  logic [REG_AW-1:0] rdD,
   input  logic              use_rs1D,
   input  logic              use_rs2D,
   input  logic              reg_writeD,
   input  logic              md_issueD,
   input  logic [REG_AW-1:0] rs1E,
   input  logic [REG_AW-1:0] rs2E,
   input  logic [REG_AW-1:0] rdE,
   input  logic              reg_writeE,
   input  logic              mem_to_regE,
   input  logic              md_issueE,
   input  logic [REG_AW-1:0] rdM,
   input  logic [REG_AW-1:0] rdW,
   input  logic              reg_writeM,
   input  logic              reg_writeW,
   input  logic              md_wb_valid,
   input  logic [REG_AW-1:0] md_wb_rd,
   input  logic              dmem_reqM,
   input  logic              dmem_ready,
   input  logic              br_taken,
   output logic [1:0]        forward_rs1E,
   output logic [1:0]        forward_rs2E,
   output logic              stallF,
   output logic              stallD,
   output logic              stallE,
   output logic              stallM,
   output logic              flushD,
   output logic              flushE,
   output logic              flushM,
   output logic              flushW,
   output logic              mem_err,
   output logic [CNT_W-1:0]  stall_cycles
);

   localparam int unsigned WAIT_W = (MEM_TMO > 2) ? $clog2(MEM_TMO) : 1;

   sched_state_e      state;
   logic [WAIT_W-1:0] wait_cnt;
   logic              mem_stall, load_use, md_hazard, d_hazard, md_issue_ok;
   fwd_sel_e          fwd1, fwd2;

   // Loads always write a register and mul/div ops never assert reg_writeE,
   // so the E write enable adds nothing to any decision made here.
   logic unused_reg_writeE;
   assign unused_reg_writeE = reg_writeE;

   // Forwarding; x0 is never forwarded.
   assign fwd1 = fwd_pick(reg_writeM && (rdM != '0) && (rdM == rs1E),
                          reg_writeW && (rdW != '0) && (rdW == rs1E));
   assign fwd2 = fwd_pick(reg_writeM && (rdM != '0) && (rdM == rs2E),
                          reg_writeW && (rdW != '0) && (rdW == rs2E));
   assign forward_rs1E = fwd1;
   assign forward_rs2E = fwd2;

   // Combinational so the very first wait cycle already holds the pipe.
   assign mem_stall = dmem_reqM && !dmem_ready && (state != ST_MEM_ERR);

   assign load_use = mem_to_regE && (rdE != '0) &&
                     ((use_rs1D && (rdE == rs1D)) || (use_rs2D && (rdE == rs2D)));
   assign d_hazard = load_use || md_hazard;

   // A mul/div in E only counts as issued if E actually advances.
   assign md_issue_ok = md_issueE && !mem_stall && (state != ST_MEM_ERR);

   rv_md_scoreboard #(
      .NREG     (NREG),
      .MD_DEPTH (MD_DEPTH),
      .REG_AW   (REG_AW)
   ) u_md_sb (
      .clk        (clk),
      .rst_n      (rst_n),
      .rs1D       (rs1D),
      .rs2D       (rs2D),
      .rdD        (rdD),
      .use_rs1D   (use_rs1D),
      .use_rs2D   (use_rs2D),
      .reg_writeD (reg_writeD),
      .md_issueD  (md_issueD),
      .issue      (md_issue_ok),
      .issue_rd   (rdE),
      .wb_valid   (md_wb_valid),
      .wb_rd      (md_wb_rd),
      .md_hazard  (md_hazard)
   );

   // Memory wait/timeout FSM; mem_err is high exactly while in ST_MEM_ERR.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ST_RUN;
         wait_cnt <= '0;
         mem_err  <= 1'b0;
      end else begin
         mem_err <= 1'b0;
         unique case (state)
            ST_RUN: begin
               if (dmem_reqM && !dmem_ready) begin
                  state    <= ST_MEM_WAIT;
                  wait_cnt <= WAIT_W'(1);
               end
            end
            ST_MEM_WAIT: begin
               if (dmem_ready) begin
                  state <= ST_RUN;
               end else if (wait_cnt == WAIT_W'(MEM_TMO - 1)) begin
                  state   <= ST_MEM_ERR;
                  mem_err <= 1'b1;
               end else begin
                  wait_cnt <= wait_cnt + WAIT_W'(1);
               end
            end
            ST_MEM_ERR: state <= ST_RUN;
            default:    state <= ST_RUN;
         endcase
      end
   end

   // Priority: timeout recovery > memory stall > redirect > D hazard.
   always_comb begin
      stallF = 1'b0;
      stallD = 1'b0;
      stallE = 1'b0;
      stallM = 1'b0;
      flushD = 1'b0;
      flushE = 1'b0;
      flushM = 1'b0;
      flushW = 1'b0;
      if (state == ST_MEM_ERR) begin
         flushD = 1'b1;
         flushE = 1'b1;
         flushM = 1'b1;
      end else if (mem_stall) begin
         stallF = 1'b1;
         stallD = 1'b1;
         stallE = 1'b1;
         stallM = 1'b1;
         flushW = 1'b1;
      end else if (br_taken) begin
         // D is killed by the redirect, so its hazard is irrelevant.
         flushD = 1'b1;
         flushE = 1'b1;
      end else if (d_hazard) begin
         stallF = 1'b1;
         stallD = 1'b1;
         flushE = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cycles <= '0;
      end else if (stallF && (stall_cycles != '1)) begin
         stall_cycles <= stall_cycles + CNT_W'(1);
      end
   end

endmodule
